// File: rtl/fpu_norm_pkg.sv
// Shared constants and the default-width stage-1 bundle for the FPU add/sub post-adder normaliser.
package fpu_norm_pkg;
  localparam int DEF_MANT_W = 27;
  localparam int DEF_EXP_W  = 8;
  localparam int DEF_LZC_W  = $clog2(DEF_MANT_W + 1);
  localparam int STICKY_IDX = 0;
  localparam logic [DEF_EXP_W-1:0] EXP_MAX = '1;

  typedef struct packed {
    logic                  ovf;
    logic [DEF_MANT_W-1:0] mant;
    logic [DEF_EXP_W-1:0]  exp;
    logic [DEF_LZC_W-1:0]  lzc;
    logic                  zero;
  } s1_t;
endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports a count of W.
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o,
  output logic          all_zero_o
);
  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    count_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) count_o = CW'(W - 1 - i);
    end
  end

  assign all_zero_o = ~|data_i;
endmodule

// File: rtl/fp_norm_shifter_pipe.sv
// Two-stage post-adder normaliser: stage 1 captures the adder result plus its leading-zero
// count, stage 2 applies the right/left shift, exponent adjustment and flags.
module fp_norm_shifter_pipe
  import fpu_norm_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int LZC_W  = $clog2(MANT_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ovf,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);
  // Handshake: a beat moves across an interface on the edge where valid & ready are both high;
  // a stage with valid set and no downstream room holds its contents unchanged.
  typedef struct packed {
    logic              ovf;
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic [LZC_W-1:0]  lzc;
    logic              zero;
  } stage1_t;

  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
  localparam logic [EXP_W:0]   ONE_X    = 1;

  stage1_t           s1_q, s1_d;
  logic              s1_valid_q;
  logic              s2_load;
  logic [LZC_W-1:0]  lzc_cnt;
  logic              lzc_zero;

  logic              out_valid_q;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [EXP_W:0]    exp_x, lzc_x, exp_inc;
  logic [LZC_W-1:0]  sh_amt;

  fp_lzc #(.W(MANT_W), .CW(LZC_W)) u_lzc (
    .data_i     (in_mant),
    .count_o    (lzc_cnt),
    .all_zero_o (lzc_zero)
  );

  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;

  always_comb begin
    s1_d.ovf  = in_ovf;
    s1_d.mant = in_mant;
    s1_d.exp  = in_exp;
    s1_d.lzc  = lzc_cnt;
    s1_d.zero = lzc_zero;
  end

  always_comb begin
    mant_d  = '0;
    exp_d   = '0;
    zero_d  = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    sh_amt  = '0;
    exp_x   = {1'b0, s1_q.exp};
    lzc_x   = (EXP_W + 1)'(s1_q.lzc);
    exp_inc = exp_x + ONE_X;
    if (s1_q.ovf) begin
      // The bit shifted out on the right is folded into sticky.
      mant_d = {1'b1, s1_q.mant[MANT_W-1:STICKY_IDX+2],
                s1_q.mant[STICKY_IDX+1] | s1_q.mant[STICKY_IDX]};
      if (exp_inc >= {1'b0, EXP_ALL1}) begin
        exp_d = EXP_ALL1;
        ovf_d = 1'b1;
      end else begin
        exp_d = exp_inc[EXP_W-1:0];
      end
    end else if (s1_q.zero) begin
      zero_d = 1'b1;
    end else if (exp_x > lzc_x) begin
      sh_amt = s1_q.lzc;
      exp_d  = EXP_W'(exp_x - lzc_x);
      mant_d = s1_q.mant << sh_amt;
    end else begin
      // Denormal: shift only as far as the exponent allows (exp - 1), then clamp to 0.
      sh_amt = (s1_q.exp == '0) ? '0 : LZC_W'(exp_x - ONE_X);
      unf_d  = 1'b1;
      mant_d = s1_q.mant << sh_amt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_valid && in_ready) s1_q <= s1_d;
      if (s2_load) out_valid_q <= s1_valid_q;
      if (s1_valid_q && s2_load) begin
        mant_q <= mant_d;
        exp_q  <= exp_d;
        zero_q <= zero_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_mant  = mant_q;
  assign out_exp   = exp_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
endmodule

// File: tb/tb_fp_norm_shifter_pipe.sv
// Directed vector table plus hand-written backpressure and reset sequences for the normaliser.
module tb_fp_norm_shifter_pipe;
  localparam int MW = 27;
  localparam int EW = 8;
  localparam int RW = MW + EW + 3;
  localparam int NV = 12;

  typedef struct {
    logic          ovf;
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic [MW-1:0] e_mant;
    logic [EW-1:0] e_exp;
    logic          e_zero;
    logic          e_ovf;
    logic          e_unf;
  } vec_t;

  logic          clk, rst;
  logic          in_valid, in_ready, in_ovf;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          out_valid, out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_zero, out_ovf, out_unf;

  vec_t          vecs[NV];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] drv_exp;
  logic          accepted;
  int            total = 0;
  int            bad = 0;
  int            pops = 0;
  int            bp[4] = '{0, 2, 4, 9};

  fp_norm_shifter_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ovf    (in_ovf),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout required completion", name);
  endtask

  // Evaluate both handshakes just after the falling edge, then advance one cycle.
  task automatic tick();
    logic [RW-1:0] e;
    #1;
    accepted = 1'b0;
    if (in_valid && in_ready) begin
      exp_q.push_back(drv_exp);
      accepted = 1'b1;
    end
    if (out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        timeout_fail("unexpected_out");
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({out_mant, out_exp, out_zero, out_ovf, out_unf}), 64'(e));
      end
    end
    @(negedge clk);
  endtask

  task automatic load(input int i);
    in_ovf  = vecs[i].ovf;
    in_mant = vecs[i].mant;
    in_exp  = vecs[i].exp;
    drv_exp = {vecs[i].e_mant, vecs[i].e_exp, vecs[i].e_zero, vecs[i].e_ovf, vecs[i].e_unf};
  endtask

  task automatic send(input int i);
    int n;
    load(i);
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!accepted && n < 20);
    if (!accepted) timeout_fail("send");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      timeout_fail("drain");
      exp_q.delete();
    end
  endtask

  task automatic check_latency(input string name);
    int lat;
    check({name, "_valid_low"}, 64'(out_valid), 64'd0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({name, "_cycles"}, 64'(lat), 64'd2);
  endtask

  task automatic check_idle(input string name);
    check({name, "_out_valid"}, 64'(out_valid), 64'd0);
    check({name, "_out_mant"}, 64'(out_mant), 64'd0);
    check({name, "_out_exp"}, 64'(out_exp), 64'd0);
    check({name, "_flags"}, 64'({out_zero, out_ovf, out_unf}), 64'd0);
  endtask

  initial begin
    int i, cycles;
    vecs[0]  = '{1'b1, 27'h4000001, 8'h80, 27'h6000001, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 27'h4000000, 8'hFE, 27'h6000000, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 27'h0100000, 8'h10, 27'h4000000, 8'h0A, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 27'h4000000, 8'h33, 27'h4000000, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 27'h0000100, 8'h05, 27'h0001000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 27'h0000000, 8'h40, 27'h0000000, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 27'h0000001, 8'h00, 27'h0000001, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 27'h0000001, 8'h1B, 27'h4000000, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 27'h0000001, 8'h1A, 27'h2000000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 27'h0000003, 8'h10, 27'h4000001, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 27'h2000000, 8'h01, 27'h2000000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 27'h7FFFFFF, 8'h05, 27'h7FFFFFF, 8'h06, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_ovf = 1'b0;
    in_mant = '0;
    in_exp = '0;
    drv_exp = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // One beat at a time through the table, with latency checked on each.
    for (int k = 0; k < NV; k++) begin
      send(k);
      check_latency("latency");
      drain();
    end

    // Back-to-back stream: one acceptance per cycle.
    pops = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    i = 0;
    cycles = 0;
    while (i < NV && cycles < 40) begin
      load(i);
      tick();
      if (accepted) i++;
      cycles++;
    end
    in_valid = 1'b0;
    check("throughput_cycles", 64'(cycles), 64'(NV));
    drain();
    check("throughput_count", 64'(pops), 64'(NV));

    // Backpressure: two beats buffer, then input stalls and output holds.
    pops = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    i = 0;
    repeat (3) begin
      load(bp[i]);
      tick();
      if (accepted) i++;
    end
    check("bp_accepted", 64'(i), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_out_mant", 64'(out_mant), 64'(vecs[bp[0]].e_mant));
    tick();
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_hold_mant", 64'(out_mant), 64'(vecs[bp[0]].e_mant));
    check("bp_hold_exp", 64'(out_exp), 64'(vecs[bp[0]].e_exp));
    out_ready = 1'b1;
    cycles = 0;
    while (i < 4 && cycles < 20) begin
      load(bp[i]);
      tick();
      if (accepted) i++;
      cycles++;
    end
    in_valid = 1'b0;
    drain();
    check("bp_count", 64'(pops), 64'd4);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    i = 0;
    cycles = 0;
    while (i < 2 && cycles < 10) begin
      load(i + 2);
      tick();
      if (accepted) i++;
      cycles++;
    end
    in_valid = 1'b0;
    check("rst_mid_loaded", 64'(i), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_idle("rst_mid");
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    pops = 0;
    out_ready = 1'b1;
    send(1);
    check_latency("rst_mid_latency");
    drain();
    check("rst_mid_count", 64'(pops), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_norm_shifter_pipe.md
Name: fp_norm_shifter_pipe

Overview:
Parametrised, pipelined post-adder normaliser for the FPU add/sub datapath. It replaces the single-step 1-bit right/left shifter with full normalisation:
- right shift by 1 on carry-out, with sticky preservation
- multi-bit left shift driven by leading-zero count
- exponent update, with denormal clamping and overflow, underflow and zero flags
- valid/ready handshake on both sides
It sits between the significand adder and the rounding unit.

Parameters:
MANT_W, 27, significand width incl. hidden bit (bit MANT_W-1) and G/R/S (bits 2:0); bit 0 is sticky
EXP_W, 8, biased exponent width
LZC_W, $clog2(MANT_W+1), width of leading-zero count / shift amount

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input this cycle
in_ovf  input  1  adder carry-out
in_mant  input  MANT_W  adder significand result
in_exp  input  EXP_W  pre-normalisation biased exponent
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_mant  output  MANT_W  normalised significand
out_exp  output  EXP_W  adjusted biased exponent
out_zero  output  1  result significand is zero
out_ovf  output  1  exponent overflowed (out_exp all ones)
out_unf  output  1  result denormal (exponent clamped to 0, significand nonzero)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_valid=0, out_mant=0, out_exp=0, all flags=0, internal stage-1 valid=0. in_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- Pipeline: 2 stages, latency 2 cycles from input handshake to out_valid.
- Stage 1 registers: ovf, mant, exp, and lzc(mant).
- Stage 2 registers: shift result and flags.
- Handshake:
  - s2_load = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_load.
  - Transfer occurs on valid&ready.
  - Outputs are held stable while out_valid & !out_ready.
  - Full throughput: 1 beat/cycle when out_ready=1.
  - No beat is lost or duplicated, and order is preserved.
- Right path (ovf=1):
  - mant_out = {ovf, mant[MANT_W-1:2], mant[1]|mant[0]}, so the sticky bit ORs in the shifted-out bit.
  - exp_out = exp+1.
  - If exp+1 = all ones: out_ovf=1, exp_out = all ones, mant passed as computed.
- Left path (ovf=0), with L = lzc(mant):
  - mant==0: out_zero=1, mant_out=0, exp_out=0, other flags 0.
  - exp > L: shift left by L (zero fill), exp_out = exp-L.
  - exp <= L (denormal): shift by (exp==0 ? 0 : exp-1), exp_out=0, out_unf=1.
  - Already normalised (L=0, exp>0): pass through unchanged.
- Arithmetic: exponent math is done at EXP_W+1 bits. Shift amount is never larger than MANT_W-1.
- Flags are mutually exclusive.

Decomposition:
- Package fpu_norm_pkg: default MANT_W/EXP_W constants, EXP_MAX (all-ones), sticky bit index, and a typedef for the stage-1 register bundle.
- Sub-module fp_lzc:
  - Parametrised leading-zero counter over MANT_W bits, combinational.
  - Outputs count and all_zero.
  - Instantiated in stage 1.

Test Plan (MANT_W=27, EXP_W=8):
1. Carry-out path: ovf=1, mant=27'h4000001, exp=8'h80, out_ready=1 -> 2 cycles later: mant=27'h6000001, exp=8'h81, all flags 0.
2. Exponent overflow: ovf=1, mant=27'h4000000, exp=8'hFE -> exp=8'hFF, out_ovf=1.
3. Multi-bit left shift: ovf=0, mant=27'h0100000 (L=6), exp=8'h10 -> mant=27'h4000000, exp=8'h0A. Then mant=27'h4000000, exp=8'h33 -> passes unchanged.
4. Denormal and zero:
   - mant=27'h0000100 (L=18), exp=8'h05 -> mant=27'h0001000, exp=0, out_unf=1.
   - mant=0, exp=8'h40 -> out_zero=1, exp=0.
5. Backpressure: stream 4 beats with out_ready=0 for 3 cycles -> out_valid held with stable data, in_ready=0 after 2 beats are buffered; on out_ready=1 all 4 emerge in order, no drops.
6. Reset mid-stream: assert rst with 2 beats in flight -> next cycle out_valid=0 and outputs zero; a new beat issued afterwards emerges after 2 cycles.
